// File: rtl/cbus_ram_model_if.sv
// CBus request/response types and the multi-port bus bundle
// shared by the memory model and its masters.
package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [63:0] data;
        logic [7:0]  strobe;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

endpackage

interface cbus_ram_model_if #(
    parameter int NPORT = 2
);
    cbus_pkg::cbus_req_t  [NPORT-1:0] oreq;
    cbus_pkg::cbus_resp_t [NPORT-1:0] oresp;

    modport master (output oreq, input oresp);
    modport slave  (input oreq, output oresp);
endinterface

// File: rtl/cbus_ram_model.sv
// Multi-port CBus RAM model: round-robin arbitration, LFSR latency,
// FIXED/INCR/WRAP bursts and sticky protocol-error flags.
module cbus_ram_model
    import cbus_pkg::*;
#(
    parameter int          NPORT     = 2,
    parameter int          DEPTH     = 65536,
    parameter logic [63:0] BASE      = 64'h8000_0000,
    parameter int          MIN_LAT   = 2,
    parameter int          MAX_LAT   = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         GW        = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic          clk,
    input  logic          reset,
    cbus_ram_model_if.slave bus,
    output logic [GW-1:0] grant_id,
    output logic          busy,
    output logic          err_mod,
    output logic          err_align,
    output logic          err_range
);

    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LRANGE = MAX_LAT - MIN_LAT + 1;

    typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

    // Transaction-defining fields; data/strobe are per-beat
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
    } ctl_t;

    state_t        state_q, state_d;
    ctl_t          ctl_q;
    ctl_t          sctl;
    ctl_t          gctl;
    cbus_req_t     greq;
    logic [GW-1:0] gid_q;
    logic [GW-1:0] rr_q;
    logic [GW-1:0] sel;
    logic [GW-1:0] pi;
    logic          found;
    logic [7:0]    beat_q;
    logic [63:0]   cur_q;
    logic [63:0]   wlo_q;
    logic [63:0]   whi_q;
    logic [15:0]   cnt_q;
    logic [15:0]   lfsr_q;
    logic          lfsr_fb;
    logic [15:0]   draw;
    logic [1:0]    ssz;
    logic [1:0]    gsz;
    logic [63:0]   span;
    logic [63:0]   wlo_d;
    logic [63:0]   amask;
    logic [63:0]   off;
    logic [63:0]   idx;
    logic [AW-1:0] widx;
    logic          in_range;
    logic [63:0]   step;
    logic [63:0]   inc;
    logic [63:0]   nxt_addr;
    logic          last_beat;
    logic          mod;

    logic [63:0] mem [DEPTH];

    // Round-robin pick: first valid port at or after rr_q
    always_comb begin
        found = 1'b0;
        sel   = '0;
        pi    = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (int'(rr_q) + i >= NPORT)
                pi = GW'(int'(rr_q) + i - NPORT);
            else
                pi = GW'(int'(rr_q) + i);
            if (!found && bus.oreq[pi].valid) begin
                found = 1'b1;
                sel   = pi;
            end
        end
    end

    assign sctl = {bus.oreq[sel].valid, bus.oreq[sel].is_write,
                   bus.oreq[sel].size, bus.oreq[sel].addr,
                   bus.oreq[sel].len, bus.oreq[sel].burst};
    assign greq = bus.oreq[gid_q];
    assign gctl = {greq.valid, greq.is_write, greq.size,
                   greq.addr, greq.len, greq.burst};

    assign ssz     = (sctl.size > 3'd3) ? 2'd3 : sctl.size[1:0];
    assign gsz     = (ctl_q.size > 3'd3) ? 2'd3 : ctl_q.size[1:0];
    assign span    = ({56'd0, sctl.len} + 64'd1) << ssz;
    assign wlo_d   = sctl.addr & ~(span - 64'd1);
    assign amask   = (64'd1 << ssz) - 64'd1;
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign draw    = 16'(MIN_LAT - 1 + (int'(lfsr_q) % LRANGE));

    assign off      = cur_q - BASE;
    assign idx      = off >> 3;
    assign in_range = (cur_q >= BASE) && (idx < 64'(DEPTH));
    assign widx     = idx[AW-1:0];

    assign step      = 64'd1 << gsz;
    assign inc       = cur_q + step;
    assign last_beat = (beat_q == ctl_q.len);
    assign mod       = (gctl != ctl_q);

    // Address of the next beat according to the burst type
    always_comb begin
        nxt_addr = cur_q;
        unique case (ctl_q.burst)
            BURST_INCR: nxt_addr = inc;
            BURST_WRAP: nxt_addr = (inc == whi_q) ? wlo_q : inc;
            default:    nxt_addr = cur_q;
        endcase
    end

    // Next state and per-port responses; only the owner sees ready
    always_comb begin
        state_d   = state_q;
        bus.oresp = '0;
        unique case (state_q)
            IDLE: begin
                if (found)
                    state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 16'd0)
                    state_d = XFER;
            end
            XFER: begin
                bus.oresp[gid_q].ready = 1'b1;
                bus.oresp[gid_q].last  = last_beat;
                bus.oresp[gid_q].data  = in_range ? mem[widx] : 64'd0;
                if (last_beat)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Transaction registers, latency LFSR and sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ctl_q     <= '0;
            gid_q     <= '0;
            rr_q      <= '0;
            beat_q    <= '0;
            cur_q     <= '0;
            wlo_q     <= '0;
            whi_q     <= '0;
            cnt_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            err_mod   <= 1'b0;
            err_align <= 1'b0;
            err_range <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        ctl_q  <= sctl;
                        gid_q  <= sel;
                        beat_q <= '0;
                        cur_q  <= sctl.addr;
                        wlo_q  <= wlo_d;
                        whi_q  <= wlo_d + span;
                        cnt_q  <= draw;
                        lfsr_q <= {lfsr_q[14:0], lfsr_fb};
                        if ((sctl.addr & amask) != 64'd0)
                            err_align <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q != 16'd0)
                        cnt_q <= cnt_q - 16'd1;
                    if (mod)
                        err_mod <= 1'b1;
                end
                XFER: begin
                    if (mod)
                        err_mod <= 1'b1;
                    if (!in_range)
                        err_range <= 1'b1;
                    beat_q <= beat_q + 8'd1;
                    cur_q  <= nxt_addr;
                    if (last_beat)
                        rr_q <= (gid_q == GW'(NPORT - 1)) ? '0 : gid_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Byte-masked write of the current beat; a reset edge suppresses it
    always_ff @(posedge clk) begin
        if (!reset && state_q == XFER && ctl_q.is_write && in_range) begin
            for (int i = 0; i < 8; i++) begin
                if (greq.strobe[i])
                    mem[widx][8*i +: 8] <= greq.data[8*i +: 8];
            end
        end
    end

    assign grant_id = gid_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_cbus_ram_model.sv
// Scoreboard bench for cbus_ram_model: drivers queue expected beats
// from a word-array model, a negedge monitor compares them.
module tb_cbus_ram_model;
    import cbus_pkg::*;

    localparam int          NP   = 2;
    localparam int          DEP  = 1024;
    localparam int          LAT  = 3;
    localparam logic [63:0] BASE = 64'h8000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic grant_id;
    logic busy, err_mod, err_align, err_range;

    cbus_ram_model_if #(.NPORT(NP)) bus();

    cbus_ram_model #(
        .NPORT(NP), .DEPTH(DEP), .BASE(BASE),
        .MIN_LAT(LAT), .MAX_LAT(LAT), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .grant_id(grant_id), .busy(busy), .err_mod(err_mod),
        .err_align(err_align), .err_range(err_range)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        bit          chk;
        bit          last;
        logic [63:0] data;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q [NP][$];
    logic [63:0] mm [longint];
    logic [63:0] wdat [NP][256];
    logic [7:0]  wstb [NP][256];
    int          grant_log [$];
    int          last_done = NP - 1;
    logic        busy_prev = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic longint widx(input logic [63:0] a);
        if (a < BASE) return -1;
        if (((a - BASE) >> 3) >= 64'(DEP)) return -1;
        return longint'((a - BASE) >> 3);
    endfunction

    function automatic logic [63:0] baddr(input logic [63:0] a, input int sz,
                                          input int len, input int burst, input int b);
        logic [63:0] st, total, lo;
        st    = 64'd1 << ((sz > 3) ? 3 : sz);
        total = 64'(len + 1) * st;
        if (burst == 1) return a + 64'(b) * st;
        if (burst == 2) begin
            lo = a & ~(total - 64'd1);
            return lo + ((a - lo) + 64'(b) * st) % total;
        end
        return a;
    endfunction

    function automatic bit known(input logic [63:0] a);
        longint i = widx(a);
        return (i < 0) || mm.exists(i);
    endfunction

    function automatic logic [63:0] mread(input logic [63:0] a);
        longint i = widx(a);
        if (i < 0 || !mm.exists(i)) return 64'd0;
        return mm[i];
    endfunction

    task automatic mwrite(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        longint      i = widx(a);
        logic [63:0] w;
        if (i < 0) return;
        w = mm.exists(i) ? mm[i] : 64'd0;
        for (int k = 0; k < 8; k++)
            if (s[k]) w[8*k +: 8] = d[8*k +: 8];
        mm[i] = w;
    endtask

    // Monitor: record grants, police idle ports, score every beat
    always @(negedge clk) begin
        exp_t e;
        if (busy && !busy_prev) grant_log.push_back(int'(grant_id));
        busy_prev = busy;
        for (int p = 0; p < NP; p++) begin
            if (!(busy && int'(grant_id) == p)) begin
                checks++;
                if (bus.oresp[p] !== '0) begin
                    errors++;
                    $display("FAIL idle_resp port%0d actual=%h required=0", p, bus.oresp[p]);
                end
            end else if (bus.oresp[p].ready) begin
                if (exp_q[p].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat port%0d actual=ready required=none", p);
                end else begin
                    e = exp_q[p].pop_front();
                    chk($sformatf("last_p%0d", p), 64'(bus.oresp[p].last), 64'(e.last));
                    if (!e.wr && e.chk)
                        chk($sformatf("rdata_p%0d", p), bus.oresp[p].data, e.data);
                end
            end
        end
    end

    // One transaction on port p; stop_at>=0 raises reset when that beat is offered
    task automatic do_txn(input int p, input bit wr, input int sz, input logic [63:0] a,
                          input int len, input int burst, input int stop_at, input bit mod);
        int b = 0;
        int lat = 0;
        int cyc = 0;
        int nb;
        nb = (stop_at >= 0) ? stop_at + 1 : len + 1;
        for (int k = 0; k < nb; k++) begin
            exp_t        e;
            logic [63:0] ba;
            ba     = baddr(a, sz, len, burst, k);
            e.wr   = wr;
            e.last = (k == len);
            e.chk  = known(ba);
            e.data = mread(ba);
            exp_q[p].push_back(e);
        end
        @(posedge clk);
        #1;
        bus.oreq[p].valid    = 1'b1;
        bus.oreq[p].is_write = wr;
        bus.oreq[p].size     = sz[2:0];
        bus.oreq[p].addr     = a;
        bus.oreq[p].len      = len[7:0];
        bus.oreq[p].burst    = burst[1:0];
        bus.oreq[p].data     = wdat[p][0];
        bus.oreq[p].strobe   = wstb[p][0];
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc > 1000) begin
                checks++;
                errors++;
                $display("FAIL timeout port%0d actual=%0d_beats required=%0d", p, b, len + 1);
                break;
            end
            if (busy && int'(grant_id) == p && !bus.oresp[p].ready) begin
                lat++;
                if (mod && lat == 1) bus.oreq[p].addr = a ^ 64'h40;
            end else if (bus.oresp[p].ready) begin
                if (b == 0) chk("latency", 64'(lat), 64'(LAT));
                if (stop_at == b) begin
                    reset = 1'b1;
                    @(posedge clk);
                    #1;
                    break;
                end
                if (wr) mwrite(baddr(a, sz, len, burst, b), wdat[p][b], wstb[p][b]);
                b++;
                @(posedge clk);
                #1;
                if (b > len) break;
                bus.oreq[p].data   = wdat[p][b];
                bus.oreq[p].strobe = wstb[p][b];
            end
        end
        bus.oreq[p] = '0;
        if (stop_at < 0) last_done = p;
    endtask

    task automatic rand_port(input int p, input int n);
        for (int t = 0; t < n; t++) begin
            int          sz, burst, len;
            bit          wr;
            logic [63:0] a;
            sz    = $urandom_range(0, 3);
            burst = $urandom_range(0, 2);
            wr    = 1'($urandom_range(0, 1));
            len   = (burst == 2) ? (1 << $urandom_range(0, 3)) - 1 : $urandom_range(0, 7);
            a     = BASE + 64'((p * 64 + 8 + $urandom_range(0, 39)) * 8)
                  + (64'($urandom_range(0, 7)) & ~((64'd1 << sz) - 64'd1));
            for (int b = 0; b <= len; b++) begin
                wdat[p][b] = {$urandom, $urandom};
                wstb[p][b] = 8'($urandom);
            end
            do_txn(p, wr, sz, a, len, burst, -1, 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        bus.oreq = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_grant", 64'(grant_id), 0);
        chk("rst_errs", 64'({err_mod, err_align, err_range}), 0);
        chk("rst_resp", 64'({bus.oresp[0].ready, bus.oresp[0].last,
                             bus.oresp[1].ready, bus.oresp[1].last}), 0);

        for (int p = 0; p < NP; p++) begin
            for (int b = 0; b < 64; b++) begin
                wdat[p][b] = {$urandom, $urandom};
                wstb[p][b] = 8'hFF;
            end
            do_txn(p, 1'b1, 3, BASE + 64'(p * 512), 63, 1, -1, 1'b0);
        end

        for (int b = 0; b < 4; b++) begin
            wdat[0][b] = 64'(b + 1);
            wstb[0][b] = 8'hFF;
        end
        do_txn(0, 1'b1, 3, BASE, 3, 1, -1, 1'b0);
        do_txn(0, 1'b0, 3, BASE, 3, 1, -1, 1'b0);
        do_txn(0, 1'b0, 3, BASE + 64'h10, 3, 2, -1, 1'b0);

        wdat[0][0] = 64'h1122_3344_5566_7788;
        wstb[0][0] = 8'hFF;
        do_txn(0, 1'b1, 3, BASE + 64'h40, 0, 1, -1, 1'b0);
        wdat[0][0] = 64'hFFFF_FFFF_FFFF_FFFF;
        wstb[0][0] = 8'h0F;
        do_txn(0, 1'b1, 3, BASE + 64'h40, 0, 1, -1, 1'b0);
        do_txn(0, 1'b0, 3, BASE + 64'h40, 0, 0, -1, 1'b0);

        grant_log.delete();
        first = (last_done + 1) % NP;
        for (int r = 0; r < 4; r++) begin
            fork
                do_txn(0, 1'b0, 3, BASE + 64'h80, 1, 1, -1, 1'b0);
                do_txn(1, 1'b0, 3, BASE + 64'd512 + 64'h80, 1, 1, -1, 1'b0);
            join
        end
        chk("arb_count", 64'(grant_log.size()), 8);
        for (int i = 0; i < grant_log.size(); i++)
            chk($sformatf("arb_order%0d", i), 64'(grant_log[i]), 64'((first + i) % NP));

        fork
            rand_port(0, 20);
            rand_port(1, 20);
        join
        @(negedge clk);
        chk("rand_errs", 64'({err_mod, err_align, err_range}), 0);

        do_txn(0, 1'b0, 3, BASE + 64'h4, 0, 1, -1, 1'b0);
        @(negedge clk);
        chk("err_align", 64'(err_align), 1);
        chk("no_err_mod", 64'(err_mod), 0);

        do_txn(0, 1'b0, 3, BASE + 64'h20, 1, 1, -1, 1'b1);
        @(negedge clk);
        chk("err_mod", 64'(err_mod), 1);
        repeat (5) @(negedge clk);
        chk("err_mod_sticky", 64'(err_mod), 1);

        chk("no_err_range", 64'(err_range), 0);
        do_txn(1, 1'b0, 3, 64'h7000_0000, 0, 1, -1, 1'b0);
        @(negedge clk);
        chk("err_range", 64'(err_range), 1);

        for (int b = 0; b < 8; b++) begin
            wdat[0][b] = {$urandom, $urandom};
            wstb[0][b] = 8'hFF;
        end
        do_txn(0, 1'b1, 3, BASE + 64'(16 * 8), 7, 1, 2, 1'b0);
        @(negedge clk);
        chk("abort_busy", 64'(busy), 0);
        chk("abort_grant", 64'(grant_id), 0);
        chk("abort_errs", 64'({err_mod, err_align, err_range}), 0);
        chk("abort_resp", 64'({bus.oresp[0].ready, bus.oresp[0].last,
                               bus.oresp[1].ready, bus.oresp[1].last}), 0);
        chk("abort_rdata", bus.oresp[0].data | bus.oresp[1].data, 0);
        reset = 1'b0;
        last_done = NP - 1;
        do_txn(0, 1'b0, 3, BASE + 64'(16 * 8), 7, 1, -1, 1'b0);

        repeat (2) @(negedge clk);
        for (int p = 0; p < NP; p++)
            chk($sformatf("pending_p%0d", p), 64'(exp_q[p].size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
